// File: rtl/lemming_track_if.sv
// rtl/lemming_track_if.sv - walker/world link: walk direction one way, wall bumps back
interface lemming_track_if;
  logic walk_left;
  logic walk_right;
  logic bump_left;
  logic bump_right;

  modport master (output walk_left, output walk_right, input bump_left, input bump_right);
  modport slave  (input walk_left, input walk_right, output bump_left, output bump_right);
endinterface

// File: rtl/lemming_track.sv
// rtl/lemming_track.sv - 1-D lemming world: bounded track position, wall bumps, step strobe, error flag
module lemming_track #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W     = 4,
  parameter int START_POS = 8,
  parameter int STEP_DIV  = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  lemming_track_if.slave       wif,
  output logic [POS_W-1:0]     pos_o,
  output logic                 step_pulse_o,
  output logic [CNT_W-1:0]     bounce_count_o,
  output logic                 dir_error_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MOVE   = 3'd1;
  localparam logic [2:0] S_BUMP_L = 3'd2;
  localparam logic [2:0] S_CHK_L  = 3'd3;
  localparam logic [2:0] S_BUMP_R = 3'd4;
  localparam logic [2:0] S_CHK_R  = 3'd5;

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(START_POS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [2:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    div_d   = div_q;
    step_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_MOVE;
          div_d   = '0;
        end
      end
      S_MOVE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          // Exactly one direction must be asserted at a tick; anything else is a walker fault.
          if (wif.walk_left && !wif.walk_right) begin
            if (pos_q != '0) begin
              pos_d  = pos_q - POS_W'(1);
              step_d = 1'b1;
            end else begin
              state_d = S_BUMP_L;
              cnt_d   = cnt_inc;
            end
          end else if (wif.walk_right && !wif.walk_left) begin
            if (pos_q != POS_MAX) begin
              pos_d  = pos_q + POS_W'(1);
              step_d = 1'b1;
            end else begin
              state_d = S_BUMP_R;
              cnt_d   = cnt_inc;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_BUMP_L: state_d = S_CHK_L;
      S_BUMP_R: state_d = S_CHK_R;
      S_CHK_L, S_CHK_R: begin
        // The walker has seen the bump for one edge, so it must be heading away from the wall now.
        if (state_q == S_CHK_L) begin
          if (!(wif.walk_right && !wif.walk_left)) err_d = 1'b1;
        end else begin
          if (!(wif.walk_left && !wif.walk_right)) err_d = 1'b1;
        end
        state_d = enable_i ? S_MOVE : S_IDLE;
        div_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= POS_INIT;
      div_q   <= '0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wif.bump_left  = (state_q == S_BUMP_L);
  assign wif.bump_right = (state_q == S_BUMP_R);
  assign pos_o          = pos_q;
  assign step_pulse_o   = step_q;
  assign bounce_count_o = cnt_q;
  assign dir_error_o    = err_q;

endmodule

// File: tb/tb_lemming_track.sv
// tb/tb_lemming_track.sv - directed checks of lemming_track with a toggling walker model
module tb_lemming_track;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       auto_walk;
  logic       man_l, man_r;
  logic       w_right;
  logic [3:0] pos;
  logic       step_pulse;
  logic [1:0] bounce_count;
  logic       dir_error;
  int         nbl = 0;
  int         nbl_snap;
  int         passes = 0;
  int         total = 0;

  lemming_track_if wif();

  lemming_track #(.TRACK_LEN(16), .POS_W(4), .START_POS(8), .STEP_DIV(4), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable_i(enable),
    .wif(wif.slave),
    .pos_o(pos),
    .step_pulse_o(step_pulse),
    .bounce_count_o(bounce_count),
    .dir_error_o(dir_error)
  );

  always #5 clk = ~clk;

  // Walker model: heads left out of reset and turns on every bump it sees.
  always @(posedge clk) begin
    if (reset) w_right <= 1'b0;
    else if (wif.bump_left) w_right <= 1'b1;
    else if (wif.bump_right) w_right <= 1'b0;
  end

  always @(posedge clk) if (wif.bump_left) nbl <= nbl + 1;

  assign wif.walk_left  = auto_walk ? !w_right : man_l;
  assign wif.walk_right = auto_walk ? w_right : man_r;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; auto_walk = 1'b1; man_l = 1'b0; man_r = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_pos", pos, 8);
    chk("rst_bl", wif.bump_left, 0);
    chk("rst_br", wif.bump_right, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_cnt", bounce_count, 0);
    chk("rst_err", dir_error, 0);

    // walk left to the wall
    enable = 1'b1;
    step(1);
    for (int k = 1; k <= 8; k++) begin
      step(3);
      chk("left_nostep", step_pulse, 0);
      step(1);
      chk("left_pos", pos, 8 - k);
      chk("left_step", step_pulse, 1);
    end
    step(4);
    chk("bl_pulse", wif.bump_left, 1);
    chk("bl_cnt", bounce_count, 1);
    chk("bl_pos", pos, 0);
    step(1);
    chk("chkl_bl", wif.bump_left, 0);
    step(1);
    chk("chkl_err", dir_error, 0);
    step(3);
    chk("away_nostep", pos, 0);
    step(1);
    chk("away_pos1", pos, 1);
    chk("away_step", step_pulse, 1);
    step(4);
    chk("away_pos2", pos, 2);

    // walk right to the wall
    repeat (13) step(4);
    chk("right_pos15", pos, 15);
    step(4);
    chk("br_pulse", wif.bump_right, 1);
    chk("br_cnt", bounce_count, 2);
    chk("br_pos", pos, 15);
    step(1);
    chk("chkr_br", wif.bump_right, 0);
    step(1);
    chk("chkr_err", dir_error, 0);
    step(4);
    chk("back_pos14", pos, 14);

    // enable gating mid-walk
    enable = 1'b0;
    step(10);
    chk("gate_pos", pos, 14);
    chk("gate_step", step_pulse, 0);
    enable = 1'b1;
    step(4);
    chk("reen_hold", pos, 14);
    step(1);
    chk("reen_pos", pos, 13);
    chk("reen_step", step_pulse, 1);

    // both directions at a tick
    auto_walk = 1'b0; man_l = 1'b1; man_r = 1'b1;
    step(4);
    chk("both_pos", pos, 13);
    chk("both_err", dir_error, 1);
    chk("both_step", step_pulse, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst2_pos", pos, 8);
    chk("rst2_err", dir_error, 0);

    // neither direction at a tick
    man_l = 1'b0; man_r = 1'b0;
    step(1);
    step(4);
    chk("none_pos", pos, 8);
    chk("none_err", dir_error, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;

    // stuck walker at the left wall
    man_l = 1'b1; man_r = 1'b0;
    step(1);
    step(32);
    chk("stuck_pos0", pos, 0);
    chk("stuck_err0", dir_error, 0);
    step(4);
    chk("stuck_bl1", wif.bump_left, 1);
    chk("stuck_cnt1", bounce_count, 1);
    step(1);
    chk("stuck_chk", wif.bump_left, 0);
    step(1);
    chk("stuck_err1", dir_error, 1);
    step(4);
    chk("stuck_bl2", wif.bump_left, 1);
    chk("stuck_cnt2", bounce_count, 2);
    chk("stuck_pos", pos, 0);
    step(6);
    chk("stuck_bl3", wif.bump_left, 1);
    chk("stuck_cnt3", bounce_count, 3);
    step(6);
    chk("stuck_bl4", wif.bump_left, 1);
    chk("stuck_sat", bounce_count, 3);

    // enable dropped during BUMP_L
    nbl_snap = nbl;
    enable = 1'b0;
    step(1);
    chk("bdis_chk", wif.bump_left, 0);
    step(10);
    chk("bdis_once", nbl - nbl_snap, 1);
    chk("bdis_pos", pos, 0);
    chk("bdis_step", step_pulse, 0);

    // reset during BUMP_R
    man_l = 1'b0; man_r = 1'b1; enable = 1'b1;
    step(1);
    step(60);
    chk("r15_pos", pos, 15);
    step(4);
    chk("rbr_pulse", wif.bump_right, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rbr_br", wif.bump_right, 0);
    chk("rbr_pos", pos, 8);
    chk("rbr_cnt", bounce_count, 0);
    chk("rbr_err", dir_error, 0);
    chk("rbr_step", step_pulse, 0);

    // reset glitch between edges is ignored
    step(1);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step(4);
    chk("glitch_pos", pos, 9);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/lemming_track.md
Name: lemming_track

Overview:
- 1-D world model for a walking Lemming. It consumes walk_left/walk_right from the walker FSM and tracks the Lemming's position on a bounded track.
- It generates the bump_left/bump_right pulses that the walker consumes, closing the walker/world loop.
- It also provides a step strobe, a bounce counter and a sticky error flag for walker misbehaviour.

Parameters:
- TRACK_LEN, 16: number of positions (0..TRACK_LEN-1); must be >= 2.
- POS_W, 4: width of pos; 2**POS_W >= TRACK_LEN.
- START_POS, 8: position loaded on reset; must be < TRACK_LEN.
- STEP_DIV, 4: clock cycles per step tick; must be >= 1.
- CNT_W, 8: width of bounce_count.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: allows motion.
- walk_left, input, 1: from the walker; the Lemming is heading left.
- walk_right, input, 1: from the walker; the Lemming is heading right.
- bump_left, output, 1: to the walker; one-cycle pulse when the left wall is hit.
- bump_right, output, 1: to the walker; one-cycle pulse when the right wall is hit.
- pos, output, POS_W: current position.
- step_pulse, output, 1: one-cycle strobe when pos changes.
- bounce_count, output, CNT_W: number of wall hits, saturating.
- dir_error, output, 1: sticky; walker direction is invalid or the walker failed to turn.

Behaviour:
- Reset (sampled only at the clk edge):
  - state=IDLE, pos=START_POS, div_cnt=0, bounce_count=0, dir_error=0.
  - bump_left, bump_right and step_pulse are all 0.
  - Reset has priority over all other inputs. Reset in any state, including mid-bounce, takes effect at the next edge.
- States: IDLE, MOVE, BUMP_L, CHK_L, BUMP_R, CHK_R.
- Output decode (outputs decoded from the state register, glitch-free):
  - bump_left = (state==BUMP_L).
  - bump_right = (state==BUMP_R).
  - Each bump is therefore exactly one cycle wide, because the walker toggles on every cycle in which it sees a bump.
- IDLE:
  - All outputs hold; pos is frozen.
  - enable=1 -> MOVE with div_cnt=0.
- MOVE:
  - enable=0 -> IDLE, div_cnt cleared, pos held.
  - Otherwise div_cnt increments each cycle. The tick occurs when div_cnt==STEP_DIV-1; at the tick, div_cnt returns to 0.
  - First step tick after entering MOVE falls at cycle STEP_DIV (counting the entry edge as cycle 0).
- At a tick, with exactly one of walk_left/walk_right high:
  - walk_left and pos>0: pos-1, step_pulse=1 for the next cycle.
  - walk_left and pos==0: -> BUMP_L, pos unchanged.
  - walk_right and pos<TRACK_LEN-1: pos+1, step_pulse=1.
  - walk_right and pos==TRACK_LEN-1: -> BUMP_R, pos unchanged.
- At a tick with both inputs high, or neither high: dir_error<=1, no move, stay in MOVE.
- BUMP_L / BUMP_R:
  - bounce_count increments on entry and saturates at 2**CNT_W-1.
  - Always advances to CHK_L / CHK_R on the next edge, regardless of enable.
- CHK_L / CHK_R:
  - The walker has had one edge to react. Required: walk_right=1 and walk_left=0 in CHK_L; the mirror in CHK_R.
  - Otherwise dir_error<=1.
  - Next state is MOVE (div_cnt=0) if enable=1, else IDLE.
  - A walker that failed to turn is re-bumped at the next tick; there is no lock-up.
- Bounce latency: wall tick edge -> bump high for 1 cycle -> check cycle -> MOVE. First step away from the wall occurs STEP_DIV cycles after re-entering MOVE.
- enable low during a bounce: the bump/check pair completes, then IDLE.
- step_pulse is registered, high one cycle after each pos change, and 0 in every non-MOVE state.
- dir_error clears only on reset.
- Position arithmetic is unsigned POS_W-bit. Wrap-around is impossible by construction, since there is no decrement at 0 and no increment at TRACK_LEN-1.

Test Plan:
- Left walk (defaults): reset, enable=1, connected walker heading left, START_POS=8.
  - pos goes 7,6,…,0 every 4 cycles with step_pulse each time.
  - Next tick gives bump_left for 1 cycle and bounce_count=1.
  - Walker turns right; pos goes 1,2,… with dir_error=0.
- Right wall (START_POS=14): walk_right held.
  - pos=15 after 4 cycles.
  - Next tick gives bump_right for 1 cycle.
  - CHK_R sees walk_left=1; no error.
- Stuck walker: drive walk_left=1 constantly from pos=0.
  - bump_left pulses once per bounce cycle, dir_error=1 after the first CHK_L, and pos stays 0.
  - bounce_count increments per bump; with CNT_W=2 it saturates at 3.
- Invalid direction: walk_left=walk_right=1 at a tick -> dir_error=1 and pos unchanged. Same for both inputs 0.
- Enable gating:
  - enable=0 for 10 cycles mid-walk -> pos frozen; after re-enable the first step is 4 cycles later.
  - enable=0 in the BUMP_L cycle -> CHK_L then IDLE, with exactly one bump pulse.
- Synchronous reset: assert reset during BUMP_R.
  - Next edge: IDLE, pos=8, bump_right=0, bounce_count=0, dir_error=0.
  - A reset pulse that rises and falls between two clk edges has no effect.
